// File: rtl/top2_pkg.sv
// Shared types and default sizing for the top-2 burst scheduler.
package top2_pkg;

   localparam int unsigned DEF_NREQ = 4;
   localparam int unsigned DEF_DW   = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      RESULT  = 2'd2
   } state_t;

endpackage

// File: rtl/top2_track.sv
// Running largest / second-largest / beat-count tracker for one burst.
// The *_c outputs are the post-update values, so a caller can latch a
// result that already includes the beat being accepted this cycle.
module top2_track
   import top2_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          beat,
   input  logic [DW-1:0] data,
   output logic [DW-1:0] max_c,
   output logic [DW-1:0] submax_c,
   output logic [7:0]    cnt_c
);

   logic [DW-1:0] max_q;
   logic [DW-1:0] submax_q;
   logic [7:0]    cnt_q;

   // Next-value computation: clear wins, otherwise top-2 insert and saturating count.
   always_comb begin
      max_c    = max_q;
      submax_c = submax_q;
      cnt_c    = cnt_q;
      if (clear) begin
         max_c    = '0;
         submax_c = '0;
         cnt_c    = '0;
      end else if (beat) begin
         if (data > max_q) begin
            max_c    = data;
            submax_c = max_q;
         end else if (data > submax_q) begin
            submax_c = data;
         end
         if (cnt_q != 8'hFF) begin
            cnt_c = cnt_q + 8'd1;
         end
      end
   end

   // Tracker state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q    <= '0;
         submax_q <= '0;
         cnt_q    <= '0;
      end else begin
         max_q    <= max_c;
         submax_q <= submax_c;
         cnt_q    <= cnt_c;
      end
   end

endmodule

// File: rtl/top2_sched.sv
// Round-robin burst scheduler reporting the two largest samples per burst.
// Optional idle-timeout abort is enabled with macro TOP2_SCHED_TIMEOUT_EN.
module top2_sched
   import top2_pkg::*;
#(
   parameter int unsigned NREQ    = DEF_NREQ,
   parameter int unsigned DW      = DEF_DW,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DW-1:0]       req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [DW-1:0]            res_max,
   output logic [DW-1:0]            res_submax,
   output logic [$clog2(NREQ)-1:0]  res_id,
   output logic [7:0]               res_cnt,
   output logic                     res_abort
);

   localparam int unsigned IDW = $clog2(NREQ);

   // Elaboration-time parameter sanity checks.
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("top2_sched: NREQ must be 2..8");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("top2_sched: TIMEOUT must be at least 1");
   end

   state_t          state, state_n;
   logic [IDW-1:0]  gnt, gnt_n;
   logic [IDW-1:0]  ptr, ptr_n;
   logic [IDW-1:0]  pick;
   logic            found;
   logic [NREQ-1:0] ready_n;
   logic            clear_c;
   logic            beat_c;
   logic            load_c;
   logic            abort_c;
   logic [DW-1:0]   max_c;
   logic [DW-1:0]   submax_c;
   logic [7:0]      cnt_c;

`ifdef TOP2_SCHED_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle, idle_n;
`endif

   top2_track #(.DW(DW)) u_track (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_c),
      .beat     (beat_c),
      .data     (req_data[gnt*DW +: DW]),
      .max_c    (max_c),
      .submax_c (submax_c),
      .cnt_c    (cnt_c)
   );

   // Next-state, arbitration and per-cycle control.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      ptr_n   = ptr;
      ready_n = '0;
      clear_c = 1'b0;
      beat_c  = 1'b0;
      load_c  = 1'b0;
      abort_c = 1'b0;
      found   = 1'b0;
      pick    = ptr;
`ifdef TOP2_SCHED_TIMEOUT_EN
      idle_n  = idle;
`endif
      // Search upward from the requester after the last one granted.
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!found && req_valid[IDW'((32'(ptr) + i) % NREQ)]) begin
            found = 1'b1;
            pick  = IDW'((32'(ptr) + i) % NREQ);
         end
      end
      case (state)
         IDLE: begin
            if (found) begin
               state_n = COLLECT;
               gnt_n   = pick;
               ptr_n   = pick;
               clear_c = 1'b1;
               ready_n = NREQ'(1) << pick;
`ifdef TOP2_SCHED_TIMEOUT_EN
               idle_n  = '0;
`endif
            end
         end
         COLLECT: begin
            beat_c  = req_valid[gnt] & req_ready[gnt];
            ready_n = req_ready;
`ifdef TOP2_SCHED_TIMEOUT_EN
            idle_n  = beat_c ? '0 : idle + TW'(1);
`endif
            if (beat_c && req_last[gnt]) begin
               state_n = RESULT;
               ready_n = '0;
               load_c  = 1'b1;
`ifdef TOP2_SCHED_TIMEOUT_EN
            end else if (!beat_c && idle == TW'(TIMEOUT - 1)) begin
               state_n = RESULT;
               ready_n = '0;
               load_c  = 1'b1;
               abort_c = 1'b1;
`endif
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, grant and arbitration pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         ptr       <= IDW'(NREQ - 1);
         req_ready <= '0;
      end else begin
         state     <= state_n;
         gnt       <= gnt_n;
         ptr       <= ptr_n;
         req_ready <= ready_n;
      end
   end

   // Result registers: loaded on burst end, held until the consumer takes them.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_max    <= '0;
         res_submax <= '0;
         res_cnt    <= '0;
         res_id     <= '0;
      end else if (load_c) begin
         res_valid  <= 1'b1;
         res_max    <= max_c;
         res_submax <= submax_c;
         res_cnt    <= cnt_c;
         res_id     <= gnt;
      end else if (state == RESULT && res_ready) begin
         res_valid  <= 1'b0;
      end
   end

`ifdef TOP2_SCHED_TIMEOUT_EN
   // Idle counter and abort flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle      <= '0;
         res_abort <= 1'b0;
      end else begin
         idle <= idle_n;
         if (load_c) begin
            res_abort <= abort_c;
         end
      end
   end
`else
   assign res_abort = 1'b0;
`endif

endmodule

// File: tb/tb_top2_sched.sv
// Directed self-checking bench for top2_sched (default NREQ=4, DW=5).
// Timeout scenario runs only when TOP2_SCHED_TIMEOUT_EN is defined.
module tb_top2_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 5;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_last;
   logic [NREQ-1:0]     req_ready;
   logic                res_valid;
   logic                res_ready;
   logic [DW-1:0]       res_max;
   logic [DW-1:0]       res_submax;
   logic [1:0]          res_id;
   logic [7:0]          res_cnt;
   logic                res_abort;

   int n_assert = 0;
   int n_fail   = 0;
   logic [DW-1:0] vec [8];

   top2_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_max    (res_max),
      .res_submax (res_submax),
      .res_id     (res_id),
      .res_cnt    (res_cnt),
      .res_abort  (res_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input int mx, input int sm, input int cn, input int id);
      check({tag, "_valid"},  32'(res_valid),  32'd1);
      check({tag, "_max"},    32'(res_max),    32'(mx));
      check({tag, "_submax"}, 32'(res_submax), 32'(sm));
      check({tag, "_cnt"},    32'(res_cnt),    32'(cn));
      check({tag, "_id"},     32'(res_id),     32'(id));
   endtask

   // Drive n beats from vec[] on requester id; returns right after the last accept edge.
   task automatic send(input logic [1:0] id, input int n, input bit with_last);
      int base;
      int b;
      base = int'(id) * DW;
      for (int k = 0; k < n; k++) begin
         req_valid[id] = 1'b1;
         req_data[base +: DW] = vec[3'(k)];
         req_last[id] = with_last && (k == n - 1);
         b = 0;
         while (!req_ready[id] && b < 40) begin
            tick();
            b++;
         end
         if (b >= 40) check("grant_wait", 32'(req_ready), 32'(1) << id);
         tick();
      end
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
   endtask

   function automatic int grant_id(input logic [NREQ-1:0] r);
      int g;
      g = -1;
      for (int i = 0; i < int'(NREQ); i++) if (r[i]) g = i;
      return g;
   endfunction

   initial begin
      int exp_ord [4];
      int exp_dat [4];
      int b;
      int g;
      logic bad;

      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b1;
      tick(); tick();
      check("rst_ready",  32'(req_ready),  32'd0);
      check("rst_valid",  32'(res_valid),  32'd0);
      check("rst_max",    32'(res_max),    32'd0);
      check("rst_submax", 32'(res_submax), 32'd0);
      check("rst_cnt",    32'(res_cnt),    32'd0);
      check("rst_id",     32'(res_id),     32'd0);
      check("rst_abort",  32'(res_abort),  32'd0);
      rst = 1'b0;
      tick();

      // Requester 0: 3,9,4,9,2 -> duplicate max fills submax
      vec = '{5'd3, 5'd9, 5'd4, 5'd9, 5'd2, 5'd0, 5'd0, 5'd0};
      send(2'd0, 5, 1'b1);
      check_result("r0_burst", 9, 9, 5, 0);
      check("r0_abort", 32'(res_abort), 32'd0);
      tick();
      check("r0_handshake", 32'(res_valid), 32'd0);

      // Requester 2: 1,5,3
      vec = '{5'd1, 5'd5, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      send(2'd2, 3, 1'b1);
      check_result("r2_burst", 5, 3, 3, 2);
      tick();

      // Requester 1: single beat 17
      vec = '{5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      send(2'd1, 1, 1'b1);
      check_result("single", 17, 0, 1, 1);
      tick();

      // Back-pressure: requester 0 waits with a large sample while 2 bursts 4,12
      req_valid[0] = 1'b1; req_last[0] = 1'b1; req_data[0 +: DW] = 5'd31;
      res_ready = 1'b0;
      vec = '{5'd4, 5'd12, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      send(2'd2, 2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         check_result("hold", 12, 4, 2, 2);
         check("hold_noready", 32'(req_ready), 32'd0);
         tick();
      end
      res_ready = 1'b1;
      tick();
      check("hold_release_valid", 32'(res_valid), 32'd0);
      check("hold_release_ready", 32'(req_ready), 32'd0);
      tick();
      check("waiter_grant", 32'(req_ready), 32'b0001);
      tick();
      check_result("waiter", 31, 0, 1, 0);
      req_valid[0] = 1'b0; req_last[0] = 1'b0;
      tick();

      // Reset mid-burst: no result, pointer returns to id 0
      vec = '{5'd20, 5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      send(2'd2, 2, 1'b0);
      rst = 1'b1;
      tick();
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_valid", 32'(res_valid), 32'd0);
      rst = 1'b0;
      req_valid = 4'b1001; req_last = 4'b1001;
      req_data[0 +: DW] = 5'd5; req_data[3*DW +: DW] = 5'd6;
      tick();
      check("postrst_grant", 32'(req_ready), 32'b0001);
      check("postrst_novalid", 32'(res_valid), 32'd0);
      req_valid[3] = 1'b0; req_last[3] = 1'b0;
      tick();
      check_result("postrst", 5, 0, 1, 0);
      req_valid = '0; req_last = '0;
      tick(); tick();

      // Round robin from reset with requesters 0,1,3 all pending
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_ord = '{0, 1, 3, 0};
      exp_dat = '{7, 2, 0, 30};
      req_data = '0;
      req_data[0 +: DW] = 5'd7; req_data[DW +: DW] = 5'd2; req_data[3*DW +: DW] = 5'd30;
      req_valid = 4'b1011; req_last = 4'b1011;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         b = 0;
         while (req_ready == '0 && b < 40) begin
            tick();
            if (!$onehot0(req_ready)) bad = 1'b1;
            b++;
         end
         g = grant_id(req_ready);
         check("rr_order", 32'(g), 32'(exp_ord[k]));
         check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
         tick();
         check_result("rr_res", exp_dat[exp_ord[k]], 0, 1, exp_ord[k]);
      end
      check("rr_overlap", 32'(bad), 32'd0);
      req_valid = '0; req_last = '0;
      tick(); tick();

`ifdef TOP2_SCHED_TIMEOUT_EN
      // Burst 6,8 then silence -> aborted partial result
      vec = '{5'd6, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      send(2'd1, 2, 1'b0);
      bad = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (res_valid !== 1'b0) bad = 1'b1;
      end
      check("to_early", 32'(bad), 32'd0);
      tick();
      check_result("timeout", 8, 6, 2, 1);
      check("to_abort", 32'(res_abort), 32'd1);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
